// File: rtl/dram_fwft_sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// dram_fwft_sync_fifo_pkg
// Shared helpers for the first-word-fall-through FIFO and its RAM:
//   clogb2()      ceiling log2, used to size addresses, pointers and counters
//   DEF_*         default geometry, with matching pointer and count widths
// ---------------------------------------------------------------------------
package dram_fwft_sync_fifo_pkg;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 32;
    // One extra pointer bit tells full from empty when the addresses match.
    localparam int DEF_PTR_WIDTH  = clogb2(DEF_FIFO_DEPTH) + 1;
    localparam int DEF_CNT_WIDTH  = clogb2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/dram_fwft_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// dram_fwft_sync_fifo_if
// Valid/ready stream bundle for the FIFO.
//   s_data/s_valid/s_ready : write side (producer -> FIFO)
//   m_data/m_valid/m_ready : read side  (FIFO -> consumer)
// Modports:
//   slave  : the FIFO itself
//   master : the environment that drives writes and accepts reads
// ---------------------------------------------------------------------------
interface dram_fwft_sync_fifo_if
    import dram_fwft_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport slave  (input  s_data, s_valid, m_ready,
                    output s_ready, m_data, m_valid);
    modport master (output s_data, s_valid, m_ready,
                    input  s_ready, m_data, m_valid);
endinterface

// File: rtl/dram_fwft_sync_fifo_dpram.sv
// ---------------------------------------------------------------------------
// dram_simple_dual_port
// Distributed simple dual-port RAM: port a writes, port b reads.
// Read latency is one clock in both build options: with the output register
// the array is read asynchronously and captured; without it the read address
// is captured and the array is read combinationally behind it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (output side only)
//   wea_i        write enable, addr_a_i / din_a_i write address and data
//   ren_b_i      read enable,  addr_b_i read address
//   dout_b_o     read data, valid the cycle after ren_b_i
// ---------------------------------------------------------------------------
module dram_simple_dual_port
    import dram_fwft_sync_fifo_pkg::*;
#(
    parameter int    mem_width           = DEF_DATA_WIDTH,
    parameter int    mem_depth           = DEF_FIFO_DEPTH,
    parameter string use_output_register = "true",
    parameter real   simulation_delay    = 1.0,
    localparam int   AW                  = clogb2(mem_depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wea_i,
    input  logic [AW-1:0]        addr_a_i,
    input  logic [mem_width-1:0] din_a_i,
    input  logic                 ren_b_i,
    input  logic [AW-1:0]        addr_b_i,
    output logic [mem_width-1:0] dout_b_o
);
    logic [mem_width-1:0] mem_q [mem_depth];

    always_ff @(posedge clk) begin
        if (wea_i) begin
            mem_q[addr_a_i] <= din_a_i;
        end
    end

    if (use_output_register == "true") begin : g_out_reg
        logic [mem_width-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (ren_b_i) begin
                dout_q <= mem_q[addr_b_i];
            end
        end
        assign dout_b_o = dout_q;
    end else begin : g_addr_reg
        logic [AW-1:0] addr_b_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_b_q <= '0;
            end else if (ren_b_i) begin
                addr_b_q <= addr_b_i;
            end
        end
        assign dout_b_o = mem_q[addr_b_q];
    end
endmodule

// File: rtl/dram_fwft_sync_fifo.sv
// ---------------------------------------------------------------------------
// dram_fwft_sync_fifo
// First-word-fall-through synchronous FIFO. Writes go straight into a
// distributed RAM; a prefetcher keeps a 2-entry skid queue topped up so the
// head word is presented on m_data whenever m_valid is high.
// Optional feature macro: FIFO_ALMOST_FLAG_EN adds almost_full/almost_empty.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous flush of all contents (m_data holds)
//   bus (slave)      s_data/s_valid/s_ready write, m_data/m_valid/m_ready read
//   count            words held: RAM + in-flight read + skid
//   almost_full      count >= ALMOST_FULL_TH  (FIFO_ALMOST_FLAG_EN only)
//   almost_empty     count <= ALMOST_EMPTY_TH (FIFO_ALMOST_FLAG_EN only)
// ---------------------------------------------------------------------------
module dram_fwft_sync_fifo
    import dram_fwft_sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int  FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int  ALMOST_FULL_TH  = 28,
    parameter int  ALMOST_EMPTY_TH = 4,
    parameter real SIM_DELAY       = 1.0,
    localparam int AW              = clogb2(FIFO_DEPTH),
    localparam int PW              = AW + 1,
    localparam int CW              = clogb2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    dram_fwft_sync_fifo_if.slave      bus,
`ifdef FIFO_ALMOST_FLAG_EN
    output logic                      almost_full,
    output logic                      almost_empty,
`endif
    output logic [CW-1:0]             count
);
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic [DATA_WIDTH-1:0] skid_q [2];
    logic [DATA_WIDTH-1:0] skid_d [2];
    logic [CW-1:0]         count_q, count_d;
    logic                  s_ready_q, s_ready_d;

    logic                  wr_fire, rd_fire, ren_b, wea;
    logic [PW-1:0]         ram_occ;
    logic [2:0]            pipe_fill;
    logic [1:0]            push_slot;
    logic [DATA_WIDTH-1:0] ram_dout;

    dram_simple_dual_port #(
        .mem_width           (DATA_WIDTH),
        .mem_depth           (FIFO_DEPTH),
        .use_output_register ("true"),
        .simulation_delay    (SIM_DELAY)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wea_i    (wea),
        .addr_a_i (wptr_q[AW-1:0]),
        .din_a_i  (bus.s_data),
        .ren_b_i  (ren_b),
        .addr_b_i (rptr_q[AW-1:0]),
        .dout_b_o (ram_dout)
    );

    always_comb begin
        wr_fire   = bus.s_valid & s_ready_q;
        rd_fire   = (skid_cnt_q != 2'd0) & bus.m_ready;
        wea       = wr_fire & ~clr;
        // Registered wptr: the slot written this cycle is never read this cycle.
        ram_occ   = wptr_q - rptr_q;
        // Skid words that will still need room next cycle if nothing pops then.
        pipe_fill = {1'b0, skid_cnt_q} - {2'b00, rd_fire} + {2'b00, inflight_q};
        ren_b     = ~clr & (ram_occ != '0) & (pipe_fill <= 3'd1);
        push_slot = skid_cnt_q - {1'b0, rd_fire};

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = inflight_q;
        skid_cnt_d = skid_cnt_q;
        skid_d[0]  = skid_q[0];
        skid_d[1]  = skid_q[1];
        count_d    = count_q;

        if (clr) begin
            // Flush: pointers and occupancy drop, skid data kept so m_data holds.
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
            skid_cnt_d = 2'd0;
            count_d    = '0;
        end else begin
            wptr_d     = wptr_q + PW'(wr_fire);
            rptr_d     = rptr_q + PW'(ren_b);
            inflight_d = ren_b;
            if (rd_fire) begin
                skid_d[0] = skid_q[1];
            end
            if (inflight_q) begin
                if (push_slot == 2'd0) begin
                    skid_d[0] = ram_dout;
                end else begin
                    skid_d[1] = ram_dout;
                end
            end
            skid_cnt_d = skid_cnt_q - {1'b0, rd_fire} + {1'b0, inflight_q};
            count_d    = count_q + CW'(wr_fire) - CW'(rd_fire);
        end
        s_ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            skid_q[0]  <= skid_d[0];
            skid_q[1]  <= skid_d[1];
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
        end
    end

`ifdef FIFO_ALMOST_FLAG_EN
    // Flags follow the next count so they change on the same edge as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_d >= CW'(ALMOST_FULL_TH));
            almost_empty <= (count_d <= CW'(ALMOST_EMPTY_TH));
        end
    end
`endif

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = (skid_cnt_q != 2'd0);
    assign bus.m_data  = skid_q[0];
    assign count       = count_q;
endmodule

// File: tb/tb_dram_fwft_sync_fifo.sv
module tb_dram_fwft_sync_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic [5:0] count;
`ifdef FIFO_ALMOST_FLAG_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    dram_fwft_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    dram_fwft_sync_fifo #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .ALMOST_FULL_TH (28),
        .ALMOST_EMPTY_TH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (bus.slave),
`ifdef FIFO_ALMOST_FLAG_EN
        .almost_full (almost_full),
        .almost_empty(almost_empty),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] model_q [$];
    logic          wr_fire_seen;
    logic          rd_fire_seen;
    logic          rd_exp_valid;
    logic [DW-1:0] rd_act;
    logic [DW-1:0] rd_exp;

    // Drive one cycle of stimulus at the negedge, let the posedge act, and
    // return at the next negedge with outputs settled. Fires are judged from
    // the handshake outputs visible before the edge.
    task automatic step(input logic sv, input logic [DW-1:0] sd,
                        input logic mr, input logic cl);
        bus.s_valid  = sv;
        bus.s_data   = sd;
        bus.m_ready  = mr;
        clr          = cl;
        wr_fire_seen = sv & bus.s_ready;
        rd_fire_seen = bus.m_valid & mr;
        rd_act       = bus.m_data;
        rd_exp_valid = 1'b0;
        rd_exp       = '0;
        @(posedge clk);
        if (cl) begin
            model_q.delete();
        end else begin
            if (rd_fire_seen && model_q.size() > 0) begin
                rd_exp       = model_q.pop_front();
                rd_exp_valid = 1'b1;
            end
            if (wr_fire_seen) model_q.push_back(sd);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic test_reset;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        clr         = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (count !== 6'd0)        begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (bus.m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        vectors++; if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
        vectors++; if (bus.m_data !== 32'h0)  begin errors++; $display("FAIL reset_m_data: got %h expected 0", bus.m_data); end
`ifdef FIFO_ALMOST_FLAG_EN
        vectors++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        vectors++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_latency;
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        vectors++; if (count !== 6'd1)       begin errors++; $display("FAIL lat_count_t0: got %0d expected 1", count); end
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_t0: got %b expected 0", bus.m_valid); end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_t1: got %b expected 0", bus.m_valid); end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL lat_valid_t2: got %b expected 1", bus.m_valid); end
        vectors++; if (bus.m_data !== 32'hA5) begin errors++; $display("FAIL lat_data_t2: got %h expected a5", bus.m_data); end
        vectors++; if (count !== 6'd1)       begin errors++; $display("FAIL lat_count_t2: got %0d expected 1", count); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (rd_fire_seen !== 1'b1 || rd_act !== 32'hA5) begin errors++; $display("FAIL lat_read: got fire=%b data=%h expected fire=1 data=a5", rd_fire_seen, rd_act); end
        vectors++; if (count !== 6'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL lat_empty: got count=%0d valid=%b expected 0/0", count, bus.m_valid); end
        // Reading an empty FIFO must not underflow.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (count !== 6'd0 || rd_fire_seen !== 1'b0) begin errors++; $display("FAIL empty_read: got count=%0d fire=%b expected 0/0", count, rd_fire_seen); end
        $display("test_latency: write a5 -> visible after two edges");
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL fill_s_ready[%0d]: got %b expected 1", i, bus.s_ready); end
            step(1'b1, DW'(i), 1'b0, 1'b0);
        end
        vectors++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b expected 0", bus.s_ready); end
        vectors++; if (count !== 6'd32)      begin errors++; $display("FAIL full_count: got %0d expected 32", count); end
        step(1'b1, 32'd99, 1'b0, 1'b0);
        vectors++; if (count !== 6'd32 || wr_fire_seen !== 1'b0) begin errors++; $display("FAIL full_refuse: got count=%0d fire=%b expected 32/0", count, wr_fire_seen); end
        $display("test_fill: 32 words stored, 33rd refused");
    endtask

    task automatic test_stream;
        int wr_next = 32;
        int rd_idx  = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, DW'(wr_next), 1'b1, 1'b0);
            if (wr_fire_seen) wr_next++;
            vectors++; if (wr_fire_seen !== (c != 0)) begin errors++; $display("FAIL stream_wfire[%0d]: got %b expected %b", c, wr_fire_seen, (c != 0)); end
            vectors++; if (rd_fire_seen !== 1'b1 || rd_act !== DW'(rd_idx)) begin errors++; $display("FAIL stream_read[%0d]: got fire=%b data=%0d expected fire=1 data=%0d", c, rd_fire_seen, rd_act, rd_idx); end
            rd_idx++;
            vectors++; if (count !== 6'd31) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 31", c, count); end
        end
        for (int c = 0; c < 100 && count != 6'd0; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (rd_fire_seen) begin
                vectors++; if (rd_act !== DW'(rd_idx)) begin errors++; $display("FAIL drain_read: got %0d expected %0d", rd_act, rd_idx); end
                rd_idx++;
            end
        end
        vectors++; if (rd_idx !== 131 || count !== 6'd0) begin errors++; $display("FAIL stream_total: got reads=%0d count=%0d expected 131/0", rd_idx, count); end
        $display("test_stream: %0d words passed through in order", rd_idx);
    endtask

    task automatic test_random;
        int wr_cnt = 0;
        int cyc    = 0;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        while ((wr_cnt < 10000 || model_q.size() > 0) && cyc < 60000) begin
            step((wr_cnt < 10000) ? 1'($urandom_range(0, 1)) : 1'b0, DW'($urandom),
                 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
            if (wr_fire_seen) wr_cnt++;
            if (rd_fire_seen) begin
                vectors++;
                if (!rd_exp_valid || rd_act !== rd_exp) begin
                    errors++;
                    if (errors < 20) $display("FAIL rand_data: got %h expected %h (have=%b)", rd_act, rd_exp, rd_exp_valid);
                end
            end
            vectors++;
            if (int'(count) != model_q.size() || count > 6'd32) begin
                errors++;
                if (errors < 20) $display("FAIL rand_count: got %0d expected %0d", count, model_q.size());
            end
            vectors++;
            if (bus.s_ready !== (model_q.size() != DEPTH)) begin
                errors++;
                if (errors < 20) $display("FAIL rand_s_ready: got %b expected %b", bus.s_ready, (model_q.size() != DEPTH));
            end
        end
        vectors++; if (model_q.size() != 0 || wr_cnt != 10000) begin errors++; $display("FAIL rand_timeout: got left=%0d written=%0d expected 0/10000", model_q.size(), wr_cnt); end
        $display("test_random: %0d words in %0d cycles", wr_cnt, cyc);
    endtask

    task automatic test_clr;
        logic [DW-1:0] held;
        for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        // This pop launches a RAM read that returns on the clr edge.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (rd_act !== 32'h100) begin errors++; $display("FAIL clr_pre_read: got %h expected 100", rd_act); end
        held = bus.m_data;
        step(1'b1, 32'hDEAD, 1'b1, 1'b1);
        vectors++; if (count !== 6'd0)       begin errors++; $display("FAIL clr_count: got %0d expected 0", count); end
        vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL clr_m_valid: got %b expected 0", bus.m_valid); end
        vectors++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL clr_s_ready: got %b expected 1", bus.s_ready); end
        vectors++; if (bus.m_data !== 32'h101 || held !== 32'h101) begin errors++; $display("FAIL clr_m_data_hold: got %h/%h expected 101", held, bus.m_data); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            vectors++; if (bus.m_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL clr_stale[%0d]: got valid=%b count=%0d expected 0/0", i, bus.m_valid, count); end
        end
        step(1'b1, 32'h1234, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h1234) begin errors++; $display("FAIL clr_after_write: got valid=%b data=%h expected 1/1234", bus.m_valid, bus.m_data); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        $display("test_clr: flush with in-flight read discarded");
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (count !== 6'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got count=%0d valid=%b expected 0/0", count, bus.m_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== 6'd0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got count=%0d valid=%b expected 0/0", count, bus.m_valid); end
        $display("test_reset_midflight: contents discarded");
    endtask

`ifdef FIFO_ALMOST_FLAG_EN
    task automatic test_almost;
        for (int i = 0; i < 28; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            vectors++; if (almost_full !== (i + 1 >= 28) || almost_empty !== (i + 1 <= 4)) begin errors++; $display("FAIL almost_fill[%0d]: got af=%b ae=%b count=%0d", i + 1, almost_full, almost_empty, count); end
        end
        vectors++; if (almost_full !== 1'b1 || count !== 6'd28) begin errors++; $display("FAIL almost_full_28: got af=%b count=%0d expected 1/28", almost_full, count); end
        for (int c = 0; c < 100 && model_q.size() > 0; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            vectors++; if (almost_empty !== (model_q.size() <= 4) || almost_full !== (model_q.size() >= 28)) begin errors++; $display("FAIL almost_drain: got af=%b ae=%b expected count=%0d", almost_full, almost_empty, model_q.size()); end
        end
        vectors++; if (almost_empty !== 1'b1 || count !== 6'd0) begin errors++; $display("FAIL almost_empty_end: got ae=%b count=%0d expected 1/0", almost_empty, count); end
        $display("test_almost: flags tracked count");
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_stream();
        test_clr();
        test_reset_midflight();
`ifdef FIFO_ALMOST_FLAG_EN
        test_almost();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
